// File: rtl/bcd_scan_receiver.sv
// Receiver for the multiplexed 4-digit BCD scan bus: captures digits on strobe edges,
// checks scan order, assembles frames and refreshes a 4-digit common 7-segment display.
module bcd_scan_receiver #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 20
) (
    input  logic        clk,
    input  logic        p3_rst_n,
    input  logic        p4_ScanSpeed,
    input  logic [3:0]  bcdcode,
    input  logic [1:0]  scan,
    input  logic        blank_lz,
    output logic [15:0] value_bcd,
    output logic        frame_valid,
    output logic        sync_err,
    output logic        digit_err,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en
);

    // state      | meaning
    // ST_HUNT    | waiting for a scan==0 digit to open a frame
    // ST_COLLECT | frame open, exp_idx holds the next scan index required
    typedef enum logic {ST_HUNT, ST_COLLECT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t      state, state_nxt;
    logic [1:0]  exp_idx, exp_idx_nxt;
    logic        s1, s2;
    logic        cap;
    logic        digit_bad;
    logic [3:0]  digit_in;
    logic        store_en;
    logic        load_en;
    logic        serr_nxt;
    logic [3:0]  sh0, sh1, sh2;

    logic [CNT_W-1:0] cnt;
    logic [1:0]  ptr;
    logic        wrap;
    logic [3:0]  digit_sel;
    logic        blank_sel;
    logic [6:0]  seg_dec;

    // Two-flop edge detector: s1 absorbs the asynchronous strobe, s2 is its delayed copy
    always_ff @(posedge clk or negedge p3_rst_n) begin
        if (!p3_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= p4_ScanSpeed;
            s2 <= s1;
        end
    end

    assign cap       = s1 & ~s2;
    assign digit_bad = (bcdcode > 4'd9);
    assign digit_in  = digit_bad ? 4'hF : bcdcode;

    always_ff @(posedge clk or negedge p3_rst_n) begin
        if (!p3_rst_n) begin
            state   <= ST_HUNT;
            exp_idx <= 2'd0;
        end else begin
            state   <= state_nxt;
            exp_idx <= exp_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        exp_idx_nxt = exp_idx;
        store_en    = 1'b0;
        load_en     = 1'b0;
        serr_nxt    = 1'b0;
        case (state)
            ST_HUNT: begin
                if (cap && scan == 2'd0) begin
                    store_en    = 1'b1;
                    exp_idx_nxt = 2'd1;
                    state_nxt   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (cap) begin
                    if (scan == exp_idx) begin
                        if (scan == 2'd3) begin
                            // units digit goes straight into value_bcd, no shadow needed
                            load_en   = 1'b1;
                            state_nxt = ST_HUNT;
                        end else begin
                            store_en    = 1'b1;
                            exp_idx_nxt = exp_idx + 2'd1;
                        end
                    end else begin
                        serr_nxt = 1'b1;
                        if (scan == 2'd0) begin
                            store_en    = 1'b1;
                            exp_idx_nxt = 2'd1;
                        end else begin
                            state_nxt = ST_HUNT;
                        end
                    end
                end
            end
            default: begin
                state_nxt   = ST_HUNT;
                exp_idx_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge p3_rst_n) begin
        if (!p3_rst_n) begin
            sh0         <= 4'd0;
            sh1         <= 4'd0;
            sh2         <= 4'd0;
            value_bcd   <= 16'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            digit_err   <= 1'b0;
        end else begin
            frame_valid <= load_en;
            sync_err    <= serr_nxt;
            if (store_en) begin
                case (scan)
                    2'd0:    sh0 <= digit_in;
                    2'd1:    sh1 <= digit_in;
                    default: sh2 <= digit_in;
                endcase
            end
            if (load_en) begin
                value_bcd <= {sh0, sh1, sh2, digit_in};
            end
            if ((store_en || load_en) && digit_bad) begin
                digit_err <= 1'b1;
            end
        end
    end

    assign wrap = (cnt == CNT_LAST);

    always_comb begin
        digit_sel = value_bcd[3:0];
        blank_sel = 1'b0;
        case (ptr)
            2'd0: begin
                digit_sel = value_bcd[3:0];
                blank_sel = 1'b0;
            end
            2'd1: begin
                digit_sel = value_bcd[7:4];
                blank_sel = blank_lz && (value_bcd[15:4] == 12'd0);
            end
            2'd2: begin
                digit_sel = value_bcd[11:8];
                blank_sel = blank_lz && (value_bcd[15:8] == 8'd0);
            end
            default: begin
                digit_sel = value_bcd[15:12];
                blank_sel = blank_lz && (value_bcd[15:12] == 4'd0);
            end
        endcase
    end

    // Segment order {g,f,e,d,c,b,a}; 4'hF marks a rejected digit as a dash
    always_comb begin
        seg_dec = 7'b0000000;
        case (digit_sel)
            4'd0:    seg_dec = 7'b0111111;
            4'd1:    seg_dec = 7'b0000110;
            4'd2:    seg_dec = 7'b1011011;
            4'd3:    seg_dec = 7'b1001111;
            4'd4:    seg_dec = 7'b1100110;
            4'd5:    seg_dec = 7'b1101101;
            4'd6:    seg_dec = 7'b1111101;
            4'd7:    seg_dec = 7'b0000111;
            4'd8:    seg_dec = 7'b1111111;
            4'd9:    seg_dec = 7'b1101111;
            4'hF:    seg_dec = 7'b1000000;
            default: seg_dec = 7'b0000000;
        endcase
    end

    // seg/dig_en only change on the wrap cycle, so a slot never mixes two values
    always_ff @(posedge clk or negedge p3_rst_n) begin
        if (!p3_rst_n) begin
            cnt    <= '0;
            ptr    <= 2'd0;
            seg    <= 7'd0;
            dig_en <= 4'd0;
        end else begin
            if (wrap) begin
                cnt    <= '0;
                ptr    <= ptr + 2'd1;
                seg    <= blank_sel ? 7'd0 : seg_dec;
                dig_en <= 4'b0001 << ptr;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/bcd_scan_receiver.md
Name: bcd_scan_receiver

Overview:
- Receiving end of the multiplexed 4-digit BCD scan bus, i.e. the `bcdcode[3:0]`, `scan[1:0]` and scan-strobe signals produced by the counter/scanner block.
- On each strobe rising edge it captures one digit and checks the scan order (0,1,2,3).
- It assembles complete frames into a stable 16-bit BCD value.
- It drives a 4-digit common 7-segment display from that value at its own refresh rate, with optional leading-zero blanking.

Parameters:
- REFRESH_DIV, 50000, clk cycles per display digit slot. Legal range 2..2^20.
- CNT_W, 20, width of the refresh counter. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- p3_rst_n  in  1  reset, asynchronous and active-low.
- p4_ScanSpeed  in  1  scan strobe from the sender, level signal. One digit is offered per rising edge. Asynchronous to clk.
- bcdcode  in  4  digit value on the bus. Stable for the whole strobe period.
- scan  in  2  digit index on the bus: 0 = thousands, 1 = hundreds, 2 = tens, 3 = units.
- blank_lz  in  1  1 = blank leading zeros on the display.
- value_bcd  out  16  last complete frame: [15:12] thousands … [3:0] units.
- frame_valid  out  1  1-cycle pulse when value_bcd updates.
- sync_err  out  1  1-cycle pulse on a scan-order violation.
- digit_err  out  1  sticky flag: some accepted digit was >9. Cleared only by reset.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dig_en  out  4  one-hot digit enable, active-high. [3] = thousands.

Behaviour:
- **Reset** (p3_rst_n=0, asynchronous), all of the following cleared:
  - value_bcd=0, shadow digits=0;
  - frame_valid=0, sync_err=0, digit_err=0;
  - seg=0, dig_en=0;
  - refresh counter=0, display pointer=0;
  - FSM=HUNT, strobe synchronisers=0.
- **Strobe synchronisation and capture:**
  - s1 <= p4_ScanSpeed; s2 <= s1.
  - cap = s1 & ~s2, i.e. exactly 1 cycle per rising edge.
  - bcdcode and scan are sampled in the cap cycle.
  - Latency from strobe edge to cap is 1–2 clk cycles.
- **Digit conditioning:** a sampled bcdcode >9 is stored as 4'hF and sets digit_err.
- **FSM, HUNT:**
  - On cap with scan==0: store digit into shadow[0], expect=1, go to COLLECT.
  - On cap with any other scan: ignore it, no error.
- **FSM, COLLECT:**
  - On cap with scan==expect: store shadow[scan], expect++.
  - When the stored scan is 3:
    - next cycle, value_bcd <= {shadow0, shadow1, shadow2, new digit};
    - frame_valid pulses in the same cycle as that load;
    - go to HUNT.
  - On cap with scan!=expect: pulse sync_err next cycle.
    - If scan==0: restart the frame (store shadow[0], expect=1, stay in COLLECT).
    - Otherwise: go to HUNT.
  - Partial frames never alter value_bcd.
- **Display refresh:**
  - The counter counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, the pointer advances 0→1→2→3→0 (0 = units).
  - seg and dig_en are registered and load on the wrap cycle, so they are first non-zero REFRESH_DIV cycles after reset.
  - dig_en = 1<<pointer.
- **7-segment decode:**
  - Standard patterns for 0–9; 4'hF shows '-' (g only).
  - Any other code shows blank.
- **Leading-zero blanking** (blank_lz=1):
  - The thousands digit is blanked if 0.
  - Hundreds is blanked if it and thousands are 0.
  - Tens is blanked if it, hundreds and thousands are all 0.
  - Units is never blanked.
  - A blanked digit drives seg=0, but dig_en still cycles.
- **Display update timing:** value_bcd changes take effect at the next digit slot load. There is no tearing within a slot.
- **Simultaneous events:** cap during a value_bcd load has no effect on that load; both actions complete.

Test Plan:
1. Reset mid-frame: after scans 0,1 have been captured, pull p3_rst_n low asynchronously, then release.
   - Required: all outputs 0, FSM in HUNT.
   - A following scan 2 is ignored with no sync_err.
2. Nominal frame: strobe edges with scan/bcd 0/1, 1/2, 2/3, 3/4.
   - Required: value_bcd=16'h1234 and a single frame_valid pulse 1 cycle after the fourth cap.
   - sync_err stays 0.
3. Order violation: scans 0,1,3.
   - Required: sync_err pulse after the third cap, value_bcd unchanged.
   - Then a full 0..3 frame with 9,9,9,9 gives value_bcd=16'h9999.
4. Bad digit: bcdcode=4'hC at scan 2 within a full frame carrying 5,6,C,7.
   - Required: value_bcd=16'h56F7, digit_err=1 and held until reset.
   - The tens slot shows seg=7'b1000000.
5. Display with REFRESH_DIV=4, value 16'h0047, blank_lz=1:
   - dig_en sequence 0001,0010,0100,1000 at 4-cycle spacing;
   - seg: units=7'b0000111 (7), tens=7'b1100110 (4), hundreds=0, thousands=0.
   - With blank_lz=0: hundreds and thousands each show 7'b0111111.
6. Strobe stretch: hold p4_ScanSpeed high for 100 cycles.
   - Required: exactly one capture; glitch-free single cap per edge.
